icache_assoc: RTL

//  Parametrised N-way set-associative, multi-word-line instruction cache with a blocking refill FSM.

---
 rtl/icache_assoc.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : icache_assoc
//  Description : N-way set-associative instruction cache with multi-word
//                lines, blocking refill, critical-word return, round-robin
//                victim selection, bulk invalidate and hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_assoc #(
    parameter int ADDR_W         = 32,
    parameter int NUM_SETS       = 1024,
    parameter int NUM_WAYS       = 2,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    input  logic              flush_i,
    output logic              flush_busy,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W - 2;
    localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int WADDR_W = INDEX_W + OFF_W;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_MISS_REQ = 3'd2,
        ST_REFILL   = 3'd3,
        ST_FLUSH    = 3'd4
    } state_t;

    state_t                           state_q, state_d;
    logic [ADDR_W-3:0]                addr_q, addr_d;        // word address of the request in flight
    logic [WAY_W-1:0]                 victim_q, victim_d;
    logic [OFF_W-1:0]                 beat_q, beat_d;
    logic [31:0]                      crit_q, crit_d;
    logic [INDEX_W-1:0]               flush_idx_q, flush_idx_d;
    logic                             rsp_valid_q, rsp_valid_d;
    logic [31:0]                      rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0]                mem_req_addr_q, mem_req_addr_d;
    logic [31:0]                      hit_cnt_q, hit_cnt_d;
    logic [31:0]                      miss_cnt_q, miss_cnt_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, valid_d;
    logic [NUM_SETS-1:0][WAY_W-1:0]    rr_q, rr_d;

    // Fields of the latched request
    logic [OFF_W-1:0]   cur_word;
    logic [INDEX_W-1:0] cur_idx;
    logic [TAG_W-1:0]   cur_tag;

    assign cur_word = addr_q[OFF_W-1:0];
    assign cur_idx  = addr_q[OFF_W +: INDEX_W];
    assign cur_tag  = addr_q[OFF_W+INDEX_W +: TAG_W];

    // Byte-offset bits of the fetch address carry no information
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];

    // Array control
    logic               rd_en;
    logic               data_we;
    logic               tag_we;
    logic [WADDR_W-1:0] rd_waddr;
    logic [WADDR_W-1:0] wr_waddr;

    assign rd_waddr = req_addr[WADDR_W+1:2];
    assign wr_waddr = {cur_idx, beat_q};

    logic [31:0]      way_data [NUM_WAYS];
    logic [TAG_W-1:0] way_tag  [NUM_WAYS];

    generate
        for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
            logic [31:0]      data_mem [NUM_SETS*WORDS_PER_LINE];
            logic [TAG_W-1:0] tag_mem  [NUM_SETS];
            logic [31:0]      rd_data_q;
            logic [TAG_W-1:0] rd_tag_q;
            logic             way_sel;

            assign way_sel = (victim_q == WAY_W'(w));

            // Data array: refill beats go to the victim way, reads launch on accept
            always_ff @(posedge CLK) begin
                if (data_we && way_sel) begin
                    data_mem[wr_waddr] <= mem_rsp_data;
                end
                if (rd_en) begin
                    rd_data_q <= data_mem[rd_waddr];
                end
            end

            // Tag array: written once when the last refill beat lands
            always_ff @(posedge CLK) begin
                if (tag_we && way_sel) begin
                    tag_mem[cur_idx] <= cur_tag;
                end
                if (rd_en) begin
                    rd_tag_q <= tag_mem[rd_waddr[WADDR_W-1:OFF_W]];
                end
            end

            assign way_data[w] = rd_data_q;
            assign way_tag[w]  = rd_tag_q;
        end
    endgenerate

    // Tag compare across all ways; descending scan so the lowest way wins
    logic             hit;
    logic [WAY_W-1:0] hit_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[cur_idx][w] && (way_tag[w] == cur_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim choice: first empty way, otherwise the set's round-robin pointer
    logic [WAY_W-1:0] victim_sel;
    logic             empty_found;

    always_comb begin
        victim_sel  = rr_q[cur_idx];
        empty_found = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!empty_found && !valid_q[cur_idx][w]) begin
                empty_found = 1'b1;
                victim_sel  = WAY_W'(w);
            end
        end
    end

    // Round-robin successor for the current set, wrapping at NUM_WAYS
    logic [WAY_W-1:0] rr_next;

    always_comb begin
        if (rr_q[cur_idx] == WAY_W'(NUM_WAYS - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = rr_q[cur_idx] + 1'b1;
        end
    end

    // Next-state, datapath and handshake decode
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        victim_d       = victim_q;
        beat_d         = beat_q;
        crit_d         = crit_q;
        flush_idx_d    = flush_idx_q;
        rsp_valid_d    = 1'b0;
        rsp_data_d     = rsp_data_q;
        mem_req_addr_d = mem_req_addr_q;
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        valid_d        = valid_q;
        rr_d           = rr_q;
        req_ready      = 1'b0;
        rd_en          = 1'b0;
        data_we        = 1'b0;
        tag_we         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    flush_idx_d = '0;
                    state_d     = ST_FLUSH;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        rd_en   = 1'b1;
                        addr_d  = req_addr[ADDR_W-1:2];
                        state_d = ST_LOOKUP;
                    end
                end
            end

            ST_LOOKUP: begin
                if (hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = way_data[hit_way];
                    if (hit_cnt_q != 32'hFFFF_FFFF) begin
                        hit_cnt_d = hit_cnt_q + 32'd1;
                    end
                    // Pipelined accept keeps streaming hits at one word per cycle
                    if (!flush_i && req_valid) begin
                        req_ready = 1'b1;
                        rd_en     = 1'b1;
                        addr_d    = req_addr[ADDR_W-1:2];
                        state_d   = ST_LOOKUP;
                    end else begin
                        req_ready = !flush_i;
                        state_d   = ST_IDLE;
                    end
                end else begin
                    if (miss_cnt_q != 32'hFFFF_FFFF) begin
                        miss_cnt_d = miss_cnt_q + 32'd1;
                    end
                    victim_d       = victim_sel;
                    beat_d         = '0;
                    mem_req_addr_d = {addr_q[ADDR_W-3:OFF_W], {(OFF_W+2){1'b0}}};
                    state_d        = ST_MISS_REQ;
                end
            end

            ST_MISS_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_REFILL;
                end
            end

            ST_REFILL: begin
                if (mem_rsp_valid) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == cur_word) begin
                        crit_d = mem_rsp_data;
                    end
                    if (beat_q == OFF_W'(WORDS_PER_LINE - 1)) begin
                        tag_we                     = 1'b1;
                        valid_d[cur_idx][victim_q] = 1'b1;
                        rr_d[cur_idx]              = rr_next;
                        rsp_valid_d                = 1'b1;
                        rsp_data_d                 = (beat_q == cur_word) ? mem_rsp_data : crit_q;
                        state_d                    = ST_IDLE;
                    end
                end
            end

            ST_FLUSH: begin
                valid_d[flush_idx_q] = '0;
                rr_d[flush_idx_q]    = '0;
                flush_idx_d          = flush_idx_q + 1'b1;
                if (flush_idx_q == INDEX_W'(NUM_SETS - 1)) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and control registers; reset abandons any refill in progress
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            victim_q       <= '0;
            beat_q         <= '0;
            crit_q         <= '0;
            flush_idx_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            mem_req_addr_q <= '0;
            hit_cnt_q      <= '0;
            miss_cnt_q     <= '0;
            valid_q        <= '0;
            rr_q           <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            victim_q       <= victim_d;
            beat_q         <= beat_d;
            crit_q         <= crit_d;
            flush_idx_q    <= flush_idx_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            mem_req_addr_q <= mem_req_addr_d;
            hit_cnt_q      <= hit_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            valid_q        <= valid_d;
            rr_q           <= rr_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign mem_req_valid = (state_q == ST_MISS_REQ);
    assign mem_req_addr  = mem_req_addr_q;
    assign flush_busy    = (state_q == ST_FLUSH);
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;

endmodule
`default_nettype wire
